// File: rtl/div_multiciclo.sv
// Multicycle signed divider: 32 restoring steps on operand magnitudes, then a sign fix-up.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module div_multiciclo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DivHI,
  output logic [WIDTH-1:0] DivLO,
  output logic             DivOut,
  output logic             divZero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic             ctrl_q;
  logic             start;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             sa_q, sa_d;
  logic             sq_q, sq_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             divout_q, divout_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] amag, bmag_in;
  logic [WIDTH:0]   shifted, diff;

  assign start   = DivCtrl & ~ctrl_q;
  assign amag    = A[WIDTH-1] ? -A : A;
  assign bmag_in = B[WIDTH-1] ? -B : B;
  // Remainder shifted left with the next dividend bit pulled in from the quotient register.
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, bmag_q};

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    bmag_d    = bmag_q;
    sa_d      = sa_q;
    sq_d      = sq_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divout_d  = 1'b0;
    divzero_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (B == '0) begin
            divzero_d = 1'b1;
          end else begin
            quo_d   = amag;
            bmag_d  = bmag_in;
            sa_d    = A[WIDTH-1];
            sq_d    = A[WIDTH-1] ^ B[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (shifted >= {1'b0, bmag_q}) begin
          rem_d = diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d     = sq_q ? -quo_q : quo_q;
        hi_d     = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        divout_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      ctrl_q    <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      bmag_q    <= '0;
      sa_q      <= 1'b0;
      sq_q      <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divout_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= DivCtrl;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      bmag_q    <= bmag_d;
      sa_q      <= sa_d;
      sq_q      <= sq_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divout_q  <= divout_d;
      divzero_q <= divzero_d;
    end
  end

  assign DivHI   = hi_q;
  assign DivLO   = lo_q;
  assign DivOut  = divout_q;
  assign divZero = divzero_q;
  assign busy    = (state_q != StIdle);

endmodule
